// File: rtl/yfill_sprite_renderer_if.sv
// ROM address/data bus between the sprite renderer and yfill_rom.
//   rom_row  : sprite-relative row address (8 bits)
//   rom_col  : sprite-relative column address (10 bits)
//   rom_data : colour returned by the ROM, one cycle after the address
// master = renderer (drives address), slave = ROM (drives data).
interface yfill_sprite_renderer_if;
    logic [7:0]  rom_row;
    logic [9:0]  rom_col;
    logic [11:0] rom_data;

    modport master (output rom_row, output rom_col, input rom_data);
    modport slave  (input rom_row, input rom_col, output rom_data);
endinterface

// File: rtl/yfill_sprite_renderer.sv
// Places the Y-fill title sprite on the 640x480 raster and composites it over
// a background colour. Three-stage pipeline: address generation (A), sideband
// delay matching the registered ROM (B), and the registered RGB output (C).
// Ports:
//   clk, reset                : pixel clock, async active-high reset
//   pix_x, pix_y, video_on    : raster position and visible-area flag
//   frame_start               : one-cycle pulse; latches position, steps frame counter
//   pos_x_in, pos_y_in        : requested sprite top-left corner
//   blink_en                  : enables 32-on/32-off frame blink
//   bg_color                  : background colour for the current pixel
//   rom                       : row/col address out, colour data back
//   rgb_out, rgb_valid        : composited colour, aligned video_on
module yfill_sprite_renderer #(
    parameter int unsigned SPRITE_W  = 584,
    parameter int unsigned SPRITE_H  = 64,
    parameter int unsigned BLINK_BIT = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     pix_x,
    input  logic [9:0]                     pix_y,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic [9:0]                     pos_x_in,
    input  logic [9:0]                     pos_y_in,
    input  logic                           blink_en,
    input  logic [11:0]                    bg_color,
    yfill_sprite_renderer_if.master        rom,
    output logic [11:0]                    rgb_out,
    output logic                           rgb_valid
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned BOX_W   = 11;
    localparam int unsigned ROW_W   = 8;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned FCNT_W  = 6;

    // Per-pixel sideband carried alongside the ROM access.
    typedef struct packed {
        logic             in_box;
        logic             visible;
        logic             von;
        logic [RGB_W-1:0] bg;
    } side_t;

    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [ROW_W-1:0]   rom_row_q, rom_row_d;
    logic [COORD_W-1:0] rom_col_q, rom_col_d;
    side_t              side_a_q, side_a_d;
    side_t              side_b_q, side_b_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               rgb_valid_q, rgb_valid_d;

    logic [BOX_W-1:0]   px, py, box_x_lo, box_x_hi, box_y_lo, box_y_hi;
    logic               in_box;
    logic               visible;

    // Frame-synchronous position latch and frame counter.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        fcnt_d  = fcnt_q;
        if (frame_start) begin
            pos_x_d = pos_x_in;
            pos_y_d = pos_y_in;
            fcnt_d  = fcnt_q + FCNT_W'(1);
        end
    end

    // Stage A: box test in 11 bits so pos + size never aliases past 1023.
    always_comb begin
        px       = BOX_W'(pix_x);
        py       = BOX_W'(pix_y);
        box_x_lo = BOX_W'(pos_x_q);
        box_y_lo = BOX_W'(pos_y_q);
        box_x_hi = box_x_lo + BOX_W'(SPRITE_W);
        box_y_hi = box_y_lo + BOX_W'(SPRITE_H);
        in_box   = video_on && (px >= box_x_lo) && (px < box_x_hi)
                            && (py >= box_y_lo) && (py < box_y_hi);
        visible  = !blink_en || !fcnt_q[BLINK_BIT];

        rom_row_d = '0;
        rom_col_d = '0;
        if (in_box) begin
            rom_row_d = ROW_W'(pix_y - pos_y_q);
            rom_col_d = pix_x - pos_x_q;
        end

        side_a_d.in_box  = in_box;
        side_a_d.visible = visible;
        side_a_d.von     = video_on;
        side_a_d.bg      = bg_color;
    end

    // Stage B/C: match ROM latency, then composite (ROM colour 0 is transparent).
    always_comb begin
        side_b_d    = side_a_q;
        rgb_d       = '0;
        rgb_valid_d = side_b_q.von;
        if (side_b_q.von) begin
            if (side_b_q.in_box && side_b_q.visible && (rom.rom_data != '0)) begin
                rgb_d = rom.rom_data;
            end else begin
                rgb_d = side_b_q.bg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            fcnt_q      <= '0;
            rom_row_q   <= '0;
            rom_col_q   <= '0;
            side_a_q    <= '0;
            side_b_q    <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            fcnt_q      <= fcnt_d;
            rom_row_q   <= rom_row_d;
            rom_col_q   <= rom_col_d;
            side_a_q    <= side_a_d;
            side_b_q    <= side_b_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign rom.rom_row = rom_row_q;
    assign rom.rom_col = rom_col_q;
    assign rgb_out     = rgb_q;
    assign rgb_valid   = rgb_valid_q;

endmodule

// File: doc/yfill_sprite_renderer.md
# yfill_sprite_renderer

Places the "Y"-fill title sprite on the 640x480 VGA raster and composites it over a background colour. It sits directly upstream of `yfill_rom` and directly downstream of it. It turns raster coordinates into sprite-relative `row`/`col` addresses, absorbs the ROM's one-cycle registered latency, and drives the final 12-bit RGB to the VGA output register. It also latches the sprite position once per frame to prevent tearing and implements an optional blink.

## Interface
- `SPRITE_W`, 584: sprite width in pixels; must match the ROM row pitch.
- `SPRITE_H`, 64: sprite height in pixels; must be ≤ 256, because `rom_row` is 8 bits.
- `BLINK_BIT`, 5: frame-counter bit that gates blink; 32 frames on, 32 frames off.
- `clk` in 1: pixel clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `pix_x` in 10: current raster column, 0..639 when visible.
- `pix_y` in 10: current raster row, 0..479 when visible.
- `video_on` in 1: raster is in the visible area.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `pos_x_in` in 10: requested sprite left edge.
- `pos_y_in` in 10: requested sprite top edge.
- `blink_en` in 1: enables blinking.
- `bg_color` in 12: background colour for the current pixel.
- `rom_row` out 8: row address to `yfill_rom`.
- `rom_col` out 10: column address to `yfill_rom`.
- `rom_data` in 12: `color_data` from `yfill_rom`, valid one cycle after the address.
- `rgb_out` out 12: composited pixel colour.
- `rgb_valid` out 1: `video_on` delayed to align with `rgb_out`.

## Operation
- **Position latch**
  - `pos_x`/`pos_y` registers load `pos_x_in`/`pos_y_in` on a cycle where `frame_start`=1.
  - They are held at all other times. Reset value is 0/0.
- **Frame counter**
  - 6-bit counter `fcnt` increments on each `frame_start` and wraps 63→0. Reset value is 0.
  - `visible` = `!blink_en` || `!fcnt[BLINK_BIT]`.
- **Stage A (registered)**
  - Box test uses 11-bit unsigned arithmetic; no wrap is allowed.
  - `in_box` = `video_on` && `pix_x`≥`pos_x` && `pix_x`<`pos_x`+`SPRITE_W` && `pix_y`≥`pos_y` && `pix_y`<`pos_y`+`SPRITE_H`.
  - `rom_row` <= `in_box` ? (`pix_y`−`pos_y`)[7:0] : 0.
  - `rom_col` <= `in_box` ? (`pix_x`−`pos_x`) : 0.
  - `in_box`, `visible`, `video_on` and `bg_color` are registered alongside the address.
- **Stage B (registered)**
  - Sideband delayed one more cycle to align with `rom_data`.
- **Stage C (registered output)**
  - if `!von_b`, then `rgb_out` <= 0;
  - else if `in_box_b` && `visible_b` && `rom_data`≠0, then `rgb_out` <= `rom_data`;
  - else `rgb_out` <= `bg_b`.
  - `rgb_valid` <= `von_b`.
- Colour 12'h000 from the ROM is transparent.
- Pixels partially off-screen are clipped naturally, because raster coordinates never exceed 639/479.

## Timing
- Latency is 3 cycles: a pixel presented in cycle t appears on `rgb_out`/`rgb_valid` in cycle t+3.
- Throughput is one pixel per clock; there is no stall.
- Reset values:
  - `rom_row`=0, `rom_col`=0, `rgb_out`=0, `rgb_valid`=0.
  - All pipeline sideband registers are 0, `pos_x`/`pos_y` are 0 and `fcnt` is 0.
- `frame_start` in cycle t:
  - The new position and `fcnt` apply to pixels sampled in cycle t+1 onward.
  - The pixel sampled in cycle t uses the old values.
- `frame_start` and a changing `pos_*_in` in the same cycle: the value present in that cycle is latched.
- `pos_*_in` changes without `frame_start` have no effect.
- `visible` is captured per pixel in stage A, so a blink transition never splits a pixel.
- Reset asserted mid-frame:
  - Outputs go to 0 immediately (asynchronously).
  - After release, the first valid output appears 3 cycles after the first sampled `video_on`=1.
- Boundaries:
  - `pix_x`=`pos_x`+`SPRITE_W`−1 is inside; `pix_x`=`pos_x`+`SPRITE_W` is outside (`rom_col`=0, `bg_color` shown).
  - `pos_x`+`SPRITE_W`>1023 must not alias, which is why the box test is 11-bit.

## Test plan
- **Reset:** assert `reset` mid-stream → `rgb_out`=0, `rgb_valid`=0, `rom_row`=0, `rom_col`=0 in the same cycle; the first valid pixel appears 3 cycles after release.
- **Opaque pixel:** `frame_start` with `pos`=(100,50), `bg_color`=12'h00F, then pixel (570,74) with `video_on`=1 → `rom_row`=24, `rom_col`=470 at t+1; `rgb_out`=12'hFFF, `rgb_valid`=1 at t+3.
- **Transparent and outside pixels:** same position, pixel (500,74) (col 400, ROM 0) → `rgb_out`=12'h00F. Pixel (684,74) → outside, `rom_col`=0, `rgb_out`=12'h00F. Pixel (683,74) → col 583, inside.
- **Blanking:** `video_on`=0 with pixel inside the box → `rgb_out`=0, `rgb_valid`=0 at t+3.
- **Position latch:** change `pos_x_in` to 200 mid-frame without `frame_start` → pixel (570,74) still white. After the next `frame_start`, the same pixel maps to col 370 (ROM 0) → `bg_color`.
- **Blink:** `blink_en`=1, issue 32 `frame_start` pulses (`fcnt`=32) → pixel (570,74) shows `bg_color`. After 32 more pulses (`fcnt` wraps to 0) → shows 12'hFFF again.
